mem_side_responder: RTL and testbench

Synthesizable memory-side endpoint for the Lx cache's `cache2mem_*` / `mem2cache_*` interface. It accepts cache-line read (`R_REQ`) and write-back (`WB_REQ`) requests from a last-level cache, services them from an internal line-wide RAM after a fixed latency, and acknowledges every request with a one-cycle `MEM_RESP`. It sits below `Lxcache_wrapper` in single-level-memory builds and in system-level benches, replacing hand-driven memory stimulus.

---
 rtl/mem_side_responder_pkg.sv | 24 ++
 rtl/mem_line_ram.sv | 45 ++++
 rtl/mem_side_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_side_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_side_responder_pkg.sv
// mem_side_responder_pkg
//   Shared cache message codes used on the cache2mem_* / mem2cache_*
//   interface. Every block on that interface imports these values rather
//   than defining its own copy.
package mem_side_responder_pkg;

  localparam int unsigned MSG_CODE_BITS = 4;

  localparam logic [3:0] NO_REQ     = 4'd0;
  localparam logic [3:0] WB_REQ     = 4'd1;
  localparam logic [3:0] R_REQ      = 4'd2;
  localparam logic [3:0] FLUSH      = 4'd3;
  localparam logic [3:0] FLUSH_S    = 4'd4;
  localparam logic [3:0] WS_BCAST   = 4'd5;
  localparam logic [3:0] RFO_BCAST  = 4'd6;
  localparam logic [3:0] REQ_FLUSH  = 4'd7;
  localparam logic [3:0] EN_ACCESS  = 4'd8;
  localparam logic [3:0] C_WB       = 4'd9;
  localparam logic [3:0] C_FLUSH    = 4'd10;
  localparam logic [3:0] MEM_RESP   = 4'd11;
  localparam logic [3:0] MEM_RESP_S = 4'd12;
  localparam logic [3:0] MEM_C_RESP = 4'd13;

endpackage : mem_side_responder_pkg

// File: rtl/mem_line_ram.sv
// mem_line_ram
//   Single-port line-wide RAM: synchronous write, registered read.
//   The read register only updates on a read access, so the last line read
//   stays on rdata until the next read. Contents are never reset.
// Ports:
//   clock  - rising-edge clock
//   en     - access enable (read when we=0, write when we=1)
//   we     - write enable
//   index  - line index
//   wdata  - line to write
//   rdata  - registered read data
module mem_line_ram #(
  parameter int WIDTH      = 128,
  parameter int INDEX_BITS = 10
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_r;

  // Line storage write port.
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem_r[index] <= wdata;
    end
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clock) begin
    if (en && !we) begin
      rdata_r <= mem_r[index];
    end
  end

  assign rdata = rdata_r;

endmodule : mem_line_ram

// File: rtl/mem_side_responder.sv
// mem_side_responder
//   Memory-side endpoint for a last-level cache. Accepts one R_REQ / WB_REQ
//   at a time, services it from an internal line RAM and acknowledges with a
//   one-cycle MEM_RESP exactly LATENCY cycles after acceptance. Unknown
//   request codes are still acknowledged (data 0) so the cache never hangs.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   cache2mem_msg/address/data   - request from the cache (held until acked)
//   mem2cache_msg/address/data   - response (MEM_RESP for one cycle, else 0)
//   mem_intf_busy                - high from acceptance until back in IDLE
//   mem_intf_address(_valid)     - address in service, qualified by busy
module mem_side_responder
  import mem_side_responder_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int ADDRESS_BITS      = 32,
  parameter int MSG_BITS          = 4,
  parameter int MEM_INDEX_BITS    = 10,
  parameter int LATENCY           = 4,
  localparam int CACHE_WIDTH      = DATA_WIDTH << CACHE_OFFSET_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache2mem_msg,
  input  logic [ADDRESS_BITS-1:0] cache2mem_address,
  input  logic [CACHE_WIDTH-1:0]  cache2mem_data,
  output logic [MSG_BITS-1:0]     mem2cache_msg,
  output logic [ADDRESS_BITS-1:0] mem2cache_address,
  output logic [CACHE_WIDTH-1:0]  mem2cache_data,
  output logic                    mem_intf_busy,
  output logic [ADDRESS_BITS-1:0] mem_intf_address,
  output logic                    mem_intf_address_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  // WAIT lasts LATENCY-1 cycles: the counter runs LATENCY-2 .. 0.
  localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 2);

  localparam logic [MSG_BITS-1:0] MSG_NO_REQ   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] MSG_WB_REQ   = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] MSG_R_REQ    = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] MSG_MEM_RESP = MSG_BITS'(MEM_RESP);

  logic [1:0]                state_r;
  logic [1:0]                state_next_s;
  logic [7:0]                count_r;
  logic [7:0]                count_next_s;
  logic                      accept_s;
  logic                      is_wb_s;
  logic                      is_rd_s;
  logic [MEM_INDEX_BITS-1:0] ram_index_s;
  logic [CACHE_WIDTH-1:0]    ram_rdata_s;
  logic [CACHE_WIDTH-1:0]    resp_data_s;

  logic [MSG_BITS-1:0]       msg_r;
  logic [ADDRESS_BITS-1:0]   addr_r;
  logic [CACHE_WIDTH-1:0]    data_r;

  logic [MSG_BITS-1:0]       resp_msg_r;
  logic [ADDRESS_BITS-1:0]   resp_addr_r;
  logic [CACHE_WIDTH-1:0]    resp_data_r;
  logic                      busy_r;

  assign is_wb_s     = (cache2mem_msg == MSG_WB_REQ);
  assign is_rd_s     = (cache2mem_msg == MSG_R_REQ);
  // Tag bits above the index are ignored, so addresses alias modulo the RAM.
  assign ram_index_s = cache2mem_address[CACHE_OFFSET_BITS +: MEM_INDEX_BITS];

  mem_line_ram #(
    .WIDTH      (CACHE_WIDTH),
    .INDEX_BITS (MEM_INDEX_BITS)
  ) u_ram (
    .clock (clock),
    .en    (accept_s && (is_wb_s || is_rd_s)),
    .we    (accept_s && is_wb_s),
    .index (ram_index_s),
    .wdata (cache2mem_data),
    .rdata (ram_rdata_s)
  );

  // Next-state and latency-counter logic.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cache2mem_msg != MSG_NO_REQ) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_next_s = ST_RESP;
          end else begin
            state_next_s = ST_WAIT;
            count_next_s = WAIT_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (count_r == 8'd0) begin
          state_next_s = ST_RESP;
        end else begin
          count_next_s = count_r - 8'd1;
        end
      end
      ST_RESP: begin
        state_next_s = ST_CLEAR;
      end
      ST_CLEAR: begin
        // The cache holds its request until it sees MEM_RESP; wait for it to
        // drop so the same request is not accepted twice.
        if (cache2mem_msg == MSG_NO_REQ) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Response data select from the captured request type.
  always_comb begin
    resp_data_s = {CACHE_WIDTH{1'b0}};
    case (msg_r)
      MSG_WB_REQ: resp_data_s = data_r;
      MSG_R_REQ:  resp_data_s = ram_rdata_s;
      default:    resp_data_s = {CACHE_WIDTH{1'b0}};
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msg_r  <= {MSG_BITS{1'b0}};
      addr_r <= {ADDRESS_BITS{1'b0}};
      data_r <= {CACHE_WIDTH{1'b0}};
    end else if (accept_s) begin
      msg_r  <= cache2mem_msg;
      addr_r <= cache2mem_address;
      data_r <= cache2mem_data;
    end
  end

  // Registered outputs; the response is launched from the RESP state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_msg_r  <= MSG_NO_REQ;
      resp_addr_r <= {ADDRESS_BITS{1'b0}};
      resp_data_r <= {CACHE_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      if (state_r == ST_RESP) begin
        resp_msg_r  <= MSG_MEM_RESP;
        resp_addr_r <= addr_r;
        resp_data_r <= resp_data_s;
      end else begin
        resp_msg_r  <= MSG_NO_REQ;
        resp_addr_r <= {ADDRESS_BITS{1'b0}};
        resp_data_r <= {CACHE_WIDTH{1'b0}};
      end
    end
  end

  assign mem2cache_msg          = resp_msg_r;
  assign mem2cache_address      = resp_addr_r;
  assign mem2cache_data         = resp_data_r;
  assign mem_intf_busy          = busy_r;
  assign mem_intf_address       = addr_r;
  assign mem_intf_address_valid = busy_r;

endmodule : mem_side_responder

// File: tb/tb_mem_side_responder.sv
// tb_mem_side_responder
//   Directed bench: two responders (LATENCY=4 and LATENCY=1) share one
//   request stream, so every transaction checks both latencies at once.
module tb_mem_side_responder;
  import mem_side_responder_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   msg;
  logic [31:0]  addr;
  logic [127:0] data;

  logic [3:0]   o0_msg,  o1_msg;
  logic [31:0]  o0_addr, o1_addr;
  logic [127:0] o0_data, o1_data;
  logic         o0_busy, o1_busy;
  logic [31:0]  o0_iaddr, o1_iaddr;
  logic         o0_valid, o1_valid;

  int compared   = 0;
  int mismatched = 0;

  // Per-transaction observations filled in by run_req.
  int           r0, r1, n0, n1, lat0, lat1;
  logic [31:0]  ra0, ra1, t1_addr0;
  logic [127:0] rd0, rd1;
  logic         hb0, hb1, t1_busy0, t1_valid0, t1_busy1, idle_after;

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] D4 = 128'h0F0F0F0F_F0F0F0F0_12121212_34343434;
  localparam logic [3:0]   BAD_MSG = 4'hF;

  mem_side_responder #(.LATENCY(4)) dut0 (
    .clock(clock), .reset(reset),
    .cache2mem_msg(msg), .cache2mem_address(addr), .cache2mem_data(data),
    .mem2cache_msg(o0_msg), .mem2cache_address(o0_addr), .mem2cache_data(o0_data),
    .mem_intf_busy(o0_busy), .mem_intf_address(o0_iaddr),
    .mem_intf_address_valid(o0_valid)
  );

  mem_side_responder #(.LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .cache2mem_msg(msg), .cache2mem_address(addr), .cache2mem_data(data),
    .mem2cache_msg(o1_msg), .mem2cache_address(o1_addr), .mem2cache_data(o1_data),
    .mem_intf_busy(o1_busy), .mem_intf_address(o1_iaddr),
    .mem_intf_address_valid(o1_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at #1 after an edge, hold it `hold` cycles past the
  // later MEM_RESP, drop it, then let both blocks return to IDLE.
  task automatic run_req(input logic [3:0] m, input logic [31:0] a,
                         input logic [127:0] d, input int hold);
    msg = m; addr = a; data = d;
    r0 = 0; r1 = 0; n0 = 0; n1 = 0; hb0 = 1'b1; hb1 = 1'b1;
    ra0 = 32'd0; ra1 = 32'd0; rd0 = 128'd0; rd1 = 128'd0;
    t1_busy0 = 1'b0; t1_valid0 = 1'b0; t1_addr0 = 32'd0; t1_busy1 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (i == 2) begin
        t1_busy0 = o0_busy; t1_valid0 = o0_valid; t1_addr0 = o0_iaddr; t1_busy1 = o1_busy;
      end
      if (r0 != 0) hb0 = hb0 & o0_busy;
      if (r1 != 0) hb1 = hb1 & o1_busy;
      if (o0_msg == MEM_RESP) begin
        n0++;
        if (r0 == 0) begin r0 = i; ra0 = o0_addr; rd0 = o0_data; end
      end
      if (o1_msg == MEM_RESP) begin
        n1++;
        if (r1 == 0) begin r1 = i; ra1 = o1_addr; rd1 = o1_data; end
      end
      if (r0 != 0 && r1 != 0 && i >= r0 + hold && i >= r1 + hold) break;
    end
    msg = NO_REQ; addr = 32'd0; data = 128'd0;
    @(posedge clock); #1;
    if (o0_msg == MEM_RESP) n0++;
    if (o1_msg == MEM_RESP) n1++;
    idle_after = !o0_busy && !o1_busy && !o0_valid && !o1_valid;
    @(posedge clock); #1;
    if (o0_msg == MEM_RESP) n0++;
    if (o1_msg == MEM_RESP) n1++;
    // Edge 1 after driving is the acceptance edge T.
    lat0 = (r0 == 0) ? -1 : r0 - 1;
    lat1 = (r1 == 0) ? -1 : r1 - 1;
  endtask

  initial begin
    reset = 1'b1; msg = NO_REQ; addr = 32'd0; data = 128'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_msg0",   128'(o0_msg),   128'(NO_REQ));
    check("rst_busy0",  128'(o0_busy),  128'd0);
    check("rst_valid0", 128'(o0_valid), 128'd0);
    check("rst_iaddr0", 128'(o0_iaddr), 128'd0);
    check("rst_data0",  o0_data,        128'd0);
    check("rst_msg1",   128'(o1_msg),   128'(NO_REQ));
    reset = 1'b0;
    @(posedge clock); #1;

    // Write-back, both latencies, echo and interface address.
    run_req(WB_REQ, 32'h11110004, D1, 0);
    check("wb_lat0",     128'(lat0),      128'd4);
    check("wb_lat1",     128'(lat1),      128'd1);
    check("wb_nresp0",   128'(n0),        128'd1);
    check("wb_nresp1",   128'(n1),        128'd1);
    check("wb_echo0",    128'(ra0),       128'h11110004);
    check("wb_data0",    rd0,             D1);
    check("wb_data1",    rd1,             D1);
    check("wb_busy_t1",  128'(t1_busy0),  128'd1);
    check("wb_valid_t1", 128'(t1_valid0), 128'd1);
    check("wb_iaddr_t1", 128'(t1_addr0),  128'h11110004);
    check("wb_idle",     128'(idle_after), 128'd1);

    // Read back the written line.
    run_req(R_REQ, 32'h11110004, D3, 0);
    check("rd_lat0",  128'(lat0), 128'd4);
    check("rd_data0", rd0,        D1);
    check("rd_data1", rd1,        D1);
    check("rd_echo1", 128'(ra1),  128'h11110004);

    // Aliasing: same index, different tag.
    run_req(WB_REQ, 32'h00000010, D2, 0);
    check("al_wb_data0", rd0, D2);
    run_req(R_REQ, 32'h00001010, 128'd0, 0);
    check("al_rd_data0", rd0,       D2);
    check("al_rd_data1", rd1,       D2);
    check("al_rd_echo0", 128'(ra0), 128'h00001010);

    // Request held 3 cycles past MEM_RESP.
    run_req(R_REQ, 32'h11110004, 128'd0, 3);
    check("hold_nresp0", 128'(n0),  128'd1);
    check("hold_nresp1", 128'(n1),  128'd1);
    check("hold_busy0",  128'(hb0), 128'd1);
    check("hold_busy1",  128'(hb1), 128'd1);
    check("hold_data0",  rd0,       D1);
    check("hold_idle",   128'(idle_after), 128'd1);

    // Unknown code: acknowledged with data 0, RAM untouched.
    run_req(BAD_MSG, 32'h00000010, D3, 0);
    check("bad_lat0",   128'(lat0), 128'd4);
    check("bad_lat1",   128'(lat1), 128'd1);
    check("bad_data0",  rd0,        128'd0);
    check("bad_data1",  rd1,        128'd0);
    check("bad_echo1",  128'(ra1),  128'h00000010);
    check("bad_idle",   128'(idle_after), 128'd1);
    run_req(R_REQ, 32'h00000010, 128'd0, 0);
    check("bad_ram_kept", rd0, D2);

    // Reset mid-transaction: dut0 in WAIT, dut1 showing MEM_RESP.
    msg = WB_REQ; addr = 32'h00000020; data = D4;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mid_busy0_pre", 128'(o0_busy), 128'd1);
    check("mid_resp1_pre", 128'(o1_msg),  128'(MEM_RESP));
    reset = 1'b1; msg = NO_REQ; addr = 32'd0; data = 128'd0;
    #1;
    check("mid_busy0",  128'(o0_busy),  128'd0);
    check("mid_valid0", 128'(o0_valid), 128'd0);
    check("mid_iaddr0", 128'(o0_iaddr), 128'd0);
    check("mid_msg1",   128'(o1_msg),   128'(NO_REQ));
    check("mid_data1",  o1_data,        128'd0);
    check("mid_addr1",  128'(o1_addr),  128'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("post_rst_idle0", 128'(o0_msg), 128'(NO_REQ));
    run_req(R_REQ, 32'h00000020, 128'd0, 0);
    check("post_rst_lat0",  128'(lat0), 128'd4);
    check("post_rst_data0", rd0,        D4);
    check("post_rst_data1", rd1,        D4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mem_side_responder
